// File: rtl/fused_cnn_pkg.sv
// Shared constants and types for the fused CNN datapath blocks.
// Holds the default OFM geometry and the writeback FSM state encoding.
package fused_cnn_pkg;

  localparam int PE_NUM         = 16;
  localparam int BYTES_PER_WORD = 4;
  localparam int OFM_W          = 56;
  localparam int OFM_H          = 56;
  localparam int OFM_C          = 32;
  localparam int OFM_ADDR_W     = 20;

  typedef enum logic [1:0] {
    WB_IDLE = 2'd0,
    WB_RUN  = 2'd1,
    WB_DONE = 2'd2
  } wb_state_t;

endpackage

// File: rtl/ofm_group_fifo.sv
// Two-entry FIFO holding whole OFM pixel groups between capture and word drain.
// A push into a full FIFO succeeds only when a pop retires the head in the same cycle.
module ofm_group_fifo #(
  parameter int DATA_W = 128
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head_data,
  output logic              full,
  output logic              empty
);

  logic [DATA_W-1:0] mem_q [2];
  logic [DATA_W-1:0] mem_d [2];
  logic              wr_ptr_q, wr_ptr_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic [1:0]        count_q, count_d;
  logic              do_push, do_pop;

  assign full      = (count_q == 2'd2);
  assign empty     = (count_q == 2'd0);
  assign head_data = mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    if (flush) begin
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/ofm_writeback_packer.sv
// Captures PE_NUM-lane OFM groups, packs them big-endian into 32-bit words and
// writes them to channel-interleaved BRAM addresses across all pixels and PE passes.
module ofm_writeback_packer
  import fused_cnn_pkg::*;
#(
  parameter int PE_NUM = fused_cnn_pkg::PE_NUM,
  parameter int OFM_W  = fused_cnn_pkg::OFM_W,
  parameter int OFM_H  = fused_cnn_pkg::OFM_H,
  parameter int OFM_C  = fused_cnn_pkg::OFM_C,
  parameter int ADDR_W = fused_cnn_pkg::OFM_ADDR_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [PE_NUM-1:0]   valid,
  input  logic [PE_NUM*8-1:0] ofm_in,
  output logic                wr_en,
  output logic [ADDR_W-1:0]   wr_addr,
  output logic [31:0]         wr_data,
  output logic                busy,
  output logic                done,
  output logic                overflow,
  output logic                lane_err
);

  localparam int WPG    = PE_NUM / BYTES_PER_WORD;
  localparam int NPIX   = OFM_W * OFM_H;
  localparam int NPASS  = OFM_C / PE_NUM;
  localparam int NGRP   = NPIX * NPASS;
  localparam int W_W    = (WPG > 1) ? $clog2(WPG) : 1;
  localparam int PIX_W  = $clog2(NPIX + 1);
  localparam int PASS_W = $clog2(NPASS + 1);
  localparam int GRP_W  = $clog2(NGRP + 1);

  wb_state_t           state_q, state_d;
  logic [W_W-1:0]      w_q, w_d;
  logic [PIX_W-1:0]    pix_q, pix_d;
  logic [PASS_W-1:0]   pass_q, pass_d;
  logic [GRP_W-1:0]    grp_cnt_q, grp_cnt_d;
  logic                wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [31:0]         wr_data_q, wr_data_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                overflow_q, overflow_d;
  logic                lane_err_q, lane_err_d;

  logic                fifo_flush, fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [PE_NUM*8-1:0] head_data;
  logic [31:0]         pack_word;
  logic [ADDR_W-1:0]   addr_now;
  logic                all_valid, any_valid, in_run, emit, last_word, push_req;

  ofm_group_fifo #(
    .DATA_W(PE_NUM * 8)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (reset),
    .flush    (fifo_flush),
    .push     (fifo_push),
    .push_data(ofm_in),
    .pop      (fifo_pop),
    .head_data(head_data),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // Lane 4w lands in the most significant byte of word w.
  for (genvar gi = 0; gi < BYTES_PER_WORD; gi++) begin : g_pack
    assign pack_word[31-8*gi -: 8] = head_data[8*(BYTES_PER_WORD*int'(w_q) + gi) +: 8];
  end

  assign addr_now = ADDR_W'(pix_q) * ADDR_W'(OFM_C / BYTES_PER_WORD)
                  + ADDR_W'(pass_q) * ADDR_W'(WPG)
                  + ADDR_W'(w_q);

  always_comb begin
    all_valid  = &valid;
    any_valid  = |valid;
    in_run     = (state_q == WB_RUN);
    emit       = in_run && !start && !fifo_empty;
    last_word  = (w_q == W_W'(WPG - 1));
    fifo_pop   = emit && last_word;
    // Groups beyond the final one of the run are not accepted at all.
    push_req   = in_run && !start && all_valid && (grp_cnt_q != GRP_W'(NGRP));
    fifo_push  = push_req && (!fifo_full || fifo_pop);
    fifo_flush = start;

    state_d    = state_q;
    w_d        = w_q;
    pix_d      = pix_q;
    pass_d     = pass_q;
    grp_cnt_d  = grp_cnt_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    overflow_d = overflow_q;
    lane_err_d = lane_err_q;

    if (start) begin
      state_d    = WB_RUN;
      w_d        = '0;
      pix_d      = '0;
      pass_d     = '0;
      grp_cnt_d  = '0;
      overflow_d = 1'b0;
      lane_err_d = 1'b0;
    end else if (in_run) begin
      if (any_valid && !all_valid) lane_err_d = 1'b1;
      if (push_req && fifo_full && !fifo_pop) overflow_d = 1'b1;
      if (fifo_push) grp_cnt_d = grp_cnt_q + GRP_W'(1);
      if (emit) begin
        wr_en_d   = 1'b1;
        wr_addr_d = addr_now;
        wr_data_d = pack_word;
        if (last_word) begin
          w_d = '0;
          if (pix_q == PIX_W'(NPIX - 1)) begin
            pix_d  = '0;
            pass_d = pass_q + PASS_W'(1);
            if (pass_q == PASS_W'(NPASS - 1)) state_d = WB_DONE;
          end else begin
            pix_d = pix_q + PIX_W'(1);
          end
        end else begin
          w_d = w_q + W_W'(1);
        end
      end
    end

    busy_d = (state_d == WB_RUN);
    done_d = (state_d == WB_DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= WB_IDLE;
      w_q        <= '0;
      pix_q      <= '0;
      pass_q     <= '0;
      grp_cnt_q  <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
      lane_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      w_q        <= w_d;
      pix_q      <= pix_d;
      pass_q     <= pass_d;
      grp_cnt_q  <= grp_cnt_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      overflow_q <= overflow_d;
      lane_err_q <= lane_err_d;
    end
  end

  assign wr_en    = wr_en_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign overflow = overflow_q;
  assign lane_err = lane_err_q;

endmodule

// File: tb/tb_ofm_writeback_packer.sv
// Randomised bench for ofm_writeback_packer on a reduced 4x3x32 OFM, checked against
// a word-queue reference model derived from the capture, packing and address rules.
module tb_ofm_writeback_packer;

  localparam int PE     = 16;
  localparam int OW     = 4;
  localparam int OH     = 3;
  localparam int OC     = 32;
  localparam int AW     = 20;
  localparam int WPG    = PE / 4;
  localparam int NPIX   = OW * OH;
  localparam int NGRP   = NPIX * (OC / PE);
  localparam int NWORDS = NPIX * OC / 4;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              start = 1'b0;
  logic [PE-1:0]     valid = '0;
  logic [PE*8-1:0]   ofm_in = '0;
  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic [31:0]       wr_data;
  logic              busy, done, overflow, lane_err;

  always #5 clk = ~clk;

  ofm_writeback_packer #(
    .PE_NUM(PE), .OFM_W(OW), .OFM_H(OH), .OFM_C(OC), .ADDR_W(AW)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .valid(valid), .ofm_in(ofm_in),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done), .overflow(overflow), .lane_err(lane_err)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference model: pending words in write order; each group contributes WPG words.
  typedef struct {
    logic [AW-1:0] a;
    logic [31:0]   d;
  } wr_t;

  wr_t           mq[$];
  int            m_state;   // 0 idle, 1 run, 2 done
  int            m_acc, m_emit;
  logic          m_ovf, m_lerr, m_wr_en;
  logic [AW-1:0] m_addr;
  logic [31:0]   m_data;

  logic [AW-1:0] act_a[$];
  logic [31:0]   act_d[$];

  task automatic model_reset();
    mq.delete();
    m_state = 0; m_acc = 0; m_emit = 0;
    m_ovf = 0; m_lerr = 0; m_wr_en = 0; m_addr = '0; m_data = '0;
  endtask

  task automatic model_step(input logic st, input logic [PE-1:0] v, input logic [PE*8-1:0] d);
    wr_t head;
    wr_t nw;
    bit  have, grp_done;
    int  occ;
    m_wr_en = 0;
    if (st) begin
      m_state = 1; mq.delete(); m_acc = 0; m_emit = 0; m_ovf = 0; m_lerr = 0;
      return;
    end
    if (m_state != 1) return;
    have     = (mq.size() > 0);
    grp_done = (mq.size() % WPG == 1) || (WPG == 1 && have);
    occ      = (mq.size() + WPG - 1) / WPG;
    if (have) head = mq.pop_front();
    if (v == {PE{1'b1}}) begin
      if (m_acc < NGRP) begin
        if (occ < 2 || grp_done) begin
          for (int w = 0; w < WPG; w++) begin
            nw.a = AW'((m_acc % NPIX) * (OC / 4) + (m_acc / NPIX) * (PE / 4) + w);
            nw.d = {d[8*(4*w)+:8], d[8*(4*w+1)+:8], d[8*(4*w+2)+:8], d[8*(4*w+3)+:8]};
            mq.push_back(nw);
          end
          m_acc++;
        end else begin
          m_ovf = 1;
        end
      end
    end else if (v != '0) begin
      m_lerr = 1;
    end
    if (have) begin
      m_wr_en = 1; m_addr = head.a; m_data = head.d; m_emit++;
      if (m_emit == NWORDS) m_state = 2;
    end
  endtask

  task automatic check_outputs();
    check_eq("wr_en", wr_en, m_wr_en);
    check_eq("wr_addr", wr_addr, m_addr);
    check_eq("wr_data", wr_data, m_data);
    check_eq("busy", busy, m_state == 1);
    check_eq("done", done, m_state == 2);
    check_eq("overflow", overflow, m_ovf);
    check_eq("lane_err", lane_err, m_lerr);
  endtask

  task automatic tick(input logic st, input logic [PE-1:0] v, input logic [PE*8-1:0] d);
    start = st; valid = v; ofm_in = d;
    model_step(st, v, d);
    @(posedge clk);
    #1;
    if (wr_en) begin
      act_a.push_back(wr_addr);
      act_d.push_back(wr_data);
    end
    $display("[TB] t=%0t st=%0b v=%h wr_en=%0b addr=%0d data=%h busy=%0b done=%0b ovf=%0b lerr=%0b",
             $time, st, v, wr_en, wr_addr, wr_data, busy, done, overflow, lane_err);
    check_outputs();
    @(negedge clk);
    start = 1'b0; valid = '0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, '0, '0);
  endtask

  task automatic group(input logic [PE*8-1:0] d);
    tick(1'b0, {PE{1'b1}}, d);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    model_reset();
    #1;
    check_outputs();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  function automatic logic [PE*8-1:0] ramp(input int base);
    logic [PE*8-1:0] r;
    for (int k = 0; k < PE; k++) r[8*k+:8] = 8'(base + k);
    return r;
  endfunction

  function automatic logic [PE*8-1:0] rnd_group();
    logic [PE*8-1:0] r;
    for (int k = 0; k < PE; k++) r[8*k+:8] = 8'($urandom_range(0, 255));
    return r;
  endfunction

  logic [31:0] t1_exp[4];
  int          n0, cyc, ones, found;
  int          hits[NWORDS];
  logic [PE-1:0] rv;

  initial begin
    t1_exp = '{32'h00010203, 32'h04050607, 32'h08090A0B, 32'h0C0D0E0F};
    model_reset();
    @(negedge clk);
    do_reset();
    idle(2);
    group(ramp(8'h40));               // ignored while idle
    idle(2);

    // Single ramp group: addresses 0..3, big-endian lane packing.
    tick(1'b1, '0, '0);
    n0 = act_a.size();
    group(ramp(0));
    idle(5);
    check_eq("t1_count", act_a.size() - n0, 4);
    for (int i = 0; i < 4; i++) begin
      check_eq("t1_addr", act_a[n0+i], i);
      check_eq("t1_data", act_d[n0+i], t1_exp[i]);
    end

    // Partial valid: flagged, dropped, pixel counter untouched.
    n0 = act_a.size();
    tick(1'b0, 16'h00FF, ramp(8'h80));
    idle(3);
    check_eq("lerr_set", lane_err, 1);
    check_eq("lerr_nowrite", act_a.size() - n0, 0);
    n0 = act_a.size();
    group(ramp(8'h10));
    idle(5);
    check_eq("lerr_next_addr", act_a[n0], 8);

    // Three back-to-back groups: third overflows.
    n0 = act_a.size();
    group(rnd_group()); group(rnd_group()); group(rnd_group());
    idle(10);
    check_eq("b2b_words", act_a.size() - n0, 8);
    check_eq("b2b_ovf", overflow, 1);

    // Restart while running, then groups every 4 cycles: no overflow, from address 0.
    tick(1'b1, '0, '0);
    n0 = act_a.size();
    for (int g = 0; g < 2; g++) begin
      group(rnd_group());
      idle(3);
    end
    idle(6);
    check_eq("sp4_words", act_a.size() - n0, 8);
    check_eq("sp4_first_addr", act_a[n0], 0);
    check_eq("sp4_ovf", overflow, 0);

    // Random traffic until the run completes.
    cyc = 0;
    while (m_state == 1 && cyc < 3000) begin
      if ($urandom_range(0, 2) == 0) rv = {PE{1'b1}};
      else if ($urandom_range(0, 15) == 0) rv = PE'($urandom);
      else rv = '0;
      tick(1'b0, rv, rnd_group());
      cyc++;
    end
    idle(2);
    check_eq("rand_done", done, 1);
    check_eq("rand_busy", busy, 0);
    n0 = act_a.size();
    group(rnd_group());
    idle(5);
    check_eq("done_ignores", act_a.size() - n0, 0);

    // Start from DONE clears everything and restarts at address 0.
    tick(1'b1, '0, '0);
    check_eq("restart_done", done, 0);
    check_eq("restart_busy", busy, 1);
    n0 = act_a.size();
    group(rnd_group());
    idle(5);
    check_eq("restart_addr", act_a[n0], 0);

    // Full run, one group every 5 cycles, each lane byte tagged with the group index.
    tick(1'b1, '0, '0);
    n0 = act_a.size();
    for (int g = 0; g < NGRP; g++) begin
      group({PE{8'(g)}});
      idle(4);
    end
    idle(5);
    check_eq("full_done", done, 1);
    check_eq("full_busy", busy, 0);
    check_eq("full_count", act_a.size() - n0, NWORDS);
    for (int i = 0; i < NWORDS; i++) hits[i] = 0;
    found = 0;
    for (int i = n0; i < act_a.size(); i++) begin
      if (act_a[i] < NWORDS) hits[act_a[i]]++;
      if (act_a[i] == 4 && found == 0) begin
        found = 1;
        check_eq("pass1_pix0_data", act_d[i], {4{8'(NPIX)}});
      end
    end
    check_eq("pass1_pix0_found", found, 1);
    ones = 0;
    for (int i = 0; i < NWORDS; i++) if (hits[i] == 1) ones++;
    check_eq("full_unique", ones, NWORDS);

    // Asynchronous reset after two of four words.
    tick(1'b1, '0, '0);
    n0 = act_a.size();
    group(ramp(8'h20));
    idle(2);
    check_eq("mid_words", act_a.size() - n0, 2);
    do_reset();
    idle(4);
    check_eq("mid_nowrite", act_a.size() - n0, 2);
    tick(1'b1, '0, '0);
    n0 = act_a.size();
    group(ramp(8'h30));
    idle(5);
    check_eq("mid_restart_addr", act_a[n0], 0);
    check_eq("mid_restart_cnt", act_a.size() - n0, 4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
